fpu_op_dispatch: RTL and testbench

//   1-to-3 dispatcher, the inverse of the 3:1 result mux. It takes one operand

---
 rtl/fpu_op_dispatch.sv | 144 ++++++++++++++
 tb/tb_fpu_op_dispatch.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_dispatch.sv
// ---------------------------------------------------------------------------
// fpu_op_dispatch
//
// Purpose:
//   1-to-3 dispatcher between FPU decode and the add/mul/div execution units.
//   Each accepted operand bundle is held in a one-entry registered stage and
//   offered to exactly one unit, chosen by the select captured with it.
//   Illegal selects (2'b11) are dropped, flagged with a one-cycle pulse and
//   counted in a saturating counter.
//
// Ports:
//   clk          in   1           clock, all state updates on posedge
//   rst_n        in   1           asynchronous active-low reset
//   in_valid     in   1           upstream request valid
//   in_ready     out  1           dispatcher can accept this cycle
//   in_data      in   DATA_WIDTH  operand bundle
//   in_sel       in   2           target: 00=unit1, 01=unit2, 10=unit3, 11=illegal
//   out_valid    out  3           one-hot valid, bit i = unit i+1
//   out_ready    in   3           per-unit ready, bit i = unit i+1
//   out_data     out  DATA_WIDTH  registered bundle shared by all units
//   err_sel      out  1           one-cycle pulse after an illegal select is accepted
//   illegal_cnt  out  CNT_WIDTH   saturating count of accepted illegal selects
// ---------------------------------------------------------------------------
module fpu_op_dispatch #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [1:0]            in_sel,
   output logic [2:0]            out_valid,
   input  logic [2:0]            out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  err_sel,
   output logic [CNT_WIDTH-1:0]  illegal_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [1:0]  sel_q;
   logic        target_ready;
   logic        fire_out;
   logic        fire_in;
   logic        legal_in;
   logic        illegal_in;

   // The held select only ever takes legal values, so the default arm never
   // fires in practice; it keeps the ready lookup total and free of
   // out-of-range indexing.
   always_comb begin
      target_ready = 1'b0;
      case (sel_q)
         2'b00:   target_ready = out_ready[0];
         2'b01:   target_ready = out_ready[1];
         2'b10:   target_ready = out_ready[2];
         default: target_ready = 1'b0;
      endcase
   end

   // Handshake terms. in_ready depends only on state and the downstream
   // ready of the held target, never on in_valid, so no combinational loop
   // can form through an upstream that waits for ready before asserting valid.
   always_comb begin
      fire_out   = (state_q == FULL) && target_ready;
      in_ready   = (state_q == EMPTY) || fire_out;
      fire_in    = in_valid && in_ready;
      legal_in   = fire_in && (in_sel != 2'b11);
      illegal_in = fire_in && (in_sel == 2'b11);
   end

   // Next-state logic. A legal accept always leaves the stage full, whether
   // it fills an empty stage or replaces a bundle leaving the same cycle.
   // Otherwise the stage drains when the held bundle is taken. An illegal
   // accept never loads the stage, so it behaves like no accept here.
   always_comb begin
      state_d = state_q;
      if (legal_in) begin
         state_d = FULL;
      end else if (fire_out) begin
         state_d = EMPTY;
      end
   end

   // State register. Reset discards any held bundle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Payload register. Data and select load only on a legal accept, which
   // can only happen when the stage is empty or being emptied, so the
   // offered bundle stays stable until it is handed off. The data is not
   // cleared when the stage drains; it is only meaningful under out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         sel_q    <= 2'b00;
      end else if (legal_in) begin
         out_data <= in_data;
         sel_q    <= in_sel;
      end
   end

   // Illegal-select bookkeeping: the error flag is a registered pulse that
   // lasts exactly the cycle after the illegal accept, and the counter
   // sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sel     <= 1'b0;
         illegal_cnt <= '0;
      end else begin
         err_sel <= illegal_in;
         if (illegal_in && (illegal_cnt != {CNT_WIDTH{1'b1}})) begin
            illegal_cnt <= illegal_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   // One-hot valid toward the units, driven straight from the held state so
   // it can only drop through a handshake or reset.
   always_comb begin
      out_valid = 3'b000;
      if (state_q == FULL) begin
         case (sel_q)
            2'b00:   out_valid = 3'b001;
            2'b01:   out_valid = 3'b010;
            2'b10:   out_valid = 3'b100;
            default: out_valid = 3'b000;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_op_dispatch.sv
// ---------------------------------------------------------------------------
// tb_fpu_op_dispatch
//
// Self-checking bench for fpu_op_dispatch. A reference model (a one-slot
// queue of pending bundles plus an illegal-select tally) predicts every
// output each cycle; a table of routing/illegal vectors and hand-written
// sequences add fixed expectations for the corner cases.
// ---------------------------------------------------------------------------
module tb_fpu_op_dispatch;

   localparam int DW      = 32;
   localparam int CW      = 8;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [1:0]    in_sel;
   logic [2:0]    out_valid;
   logic [2:0]    out_ready;
   logic [DW-1:0] out_data;
   logic          err_sel;
   logic [CW-1:0] illegal_cnt;

   int compared   = 0;
   int mismatched = 0;

   // Model state: pending bundles (at most one) and illegal tally.
   logic [DW-1:0] m_data[$];
   int            m_sel[$];
   int            m_cnt;
   bit            m_err;

   // Bundles actually handed off by the DUT, in order.
   logic [DW-1:0] dut_log_data[$];
   logic [2:0]    dut_log_valid[$];

   typedef struct {
      logic          v;
      logic [1:0]    s;
      logic [DW-1:0] d;
      logic [2:0]    r;
      logic [2:0]    ev;
      logic          ei;
      logic          chk_d;
      logic [DW-1:0] ed;
      logic          ee;
      logic [CW-1:0] ec;
   } vec_t;

   vec_t tbl[8];

   fpu_op_dispatch #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_sel      (in_sel),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .err_sel     (err_sel),
      .illegal_cnt (illegal_cnt)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison with failure reporting.
   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs (called just after a falling edge).
   task automatic applyStimulus(input logic v, input logic [1:0] s,
                                input logic [DW-1:0] d, input logic [2:0] r);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
   endtask

   // Compare every DUT output with the model's prediction for this cycle.
   task automatic checkOutput();
      logic [2:0] ev;
      logic       ei;
      ev = 3'b000;
      if (m_sel.size() != 0) ev = 3'(1 << m_sel[0]);
      ei = (m_sel.size() == 0) || out_ready[m_sel[0]];
      cmp("out_valid", 64'(out_valid), 64'(ev));
      cmp("in_ready", 64'(in_ready), 64'(ei));
      cmp("err_sel", 64'(err_sel), 64'(m_err));
      cmp("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
      if (m_sel.size() != 0) cmp("out_data", 64'(out_data), 64'(m_data[0]));
   endtask

   // Advance one clock: log DUT handoffs, update the model, return to negedge.
   task automatic advance();
      bit fo;
      bit fi;
      if ((out_valid & out_ready) != 3'b000) begin
         dut_log_data.push_back(out_data);
         dut_log_valid.push_back(out_valid);
      end
      fo = (m_sel.size() != 0) && out_ready[m_sel[0]];
      fi = in_valid && ((m_sel.size() == 0) || fo);
      @(posedge clk);
      if (fo) begin
         void'(m_sel.pop_front());
         void'(m_data.pop_front());
      end
      m_err = 1'b0;
      if (fi) begin
         if (in_sel == 2'b11) begin
            m_err = 1'b1;
            m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
         end else begin
            m_sel.push_back(int'(in_sel));
            m_data.push_back(in_data);
         end
      end
      @(negedge clk);
   endtask

   task automatic step(input logic v, input logic [1:0] s,
                       input logic [DW-1:0] d, input logic [2:0] r);
      applyStimulus(v, s, d, r);
      #1;
      checkOutput();
      advance();
   endtask

   task automatic modelReset();
      m_sel.delete();
      m_data.delete();
      m_cnt = 0;
      m_err = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] sent_data[$];
      logic [2:0]    sent_valid[$];
      logic [1:0]    rs;
      logic [DW-1:0] rd;

      // Routing and illegal-select vectors, one row per cycle from empty.
      tbl[0] = '{1'b1, 2'b00, 32'hAAAA0001, 3'b111, 3'b000, 1'b1, 1'b0, 32'h0,        1'b0, 8'd0};
      tbl[1] = '{1'b1, 2'b01, 32'hBBBB0002, 3'b111, 3'b001, 1'b1, 1'b1, 32'hAAAA0001, 1'b0, 8'd0};
      tbl[2] = '{1'b1, 2'b10, 32'hCCCC0003, 3'b111, 3'b010, 1'b1, 1'b1, 32'hBBBB0002, 1'b0, 8'd0};
      tbl[3] = '{1'b0, 2'b00, 32'h0,        3'b111, 3'b100, 1'b1, 1'b1, 32'hCCCC0003, 1'b0, 8'd0};
      tbl[4] = '{1'b0, 2'b00, 32'h0,        3'b111, 3'b000, 1'b1, 1'b0, 32'h0,        1'b0, 8'd0};
      tbl[5] = '{1'b1, 2'b11, 32'h0000DEAD, 3'b000, 3'b000, 1'b1, 1'b0, 32'h0,        1'b0, 8'd0};
      tbl[6] = '{1'b0, 2'b00, 32'h0,        3'b000, 3'b000, 1'b1, 1'b0, 32'h0,        1'b1, 8'd1};
      tbl[7] = '{1'b0, 2'b00, 32'h0,        3'b000, 3'b000, 1'b1, 1'b0, 32'h0,        1'b0, 8'd1};

      // Power-on reset.
      rst_n = 1'b0;
      applyStimulus(1'b0, 2'b00, '0, 3'b000);
      modelReset();
      @(negedge clk);
      @(negedge clk);
      #1;
      cmp("reset out_valid", 64'(out_valid), 64'h0);
      cmp("reset in_ready", 64'(in_ready), 64'h1);
      cmp("reset out_data", 64'(out_data), 64'h0);
      cmp("reset err_sel", 64'(err_sel), 64'h0);
      cmp("reset illegal_cnt", 64'(illegal_cnt), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Routing table plus first illegal select.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r);
         #1;
         cmp($sformatf("tbl%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
         cmp($sformatf("tbl%0d in_ready", i), 64'(in_ready), 64'(tbl[i].ei));
         cmp($sformatf("tbl%0d err_sel", i), 64'(err_sel), 64'(tbl[i].ee));
         cmp($sformatf("tbl%0d illegal_cnt", i), 64'(illegal_cnt), 64'(tbl[i].ec));
         if (tbl[i].chk_d) cmp($sformatf("tbl%0d out_data", i), 64'(out_data), 64'(tbl[i].ed));
         checkOutput();
         advance();
      end

      // Backpressure on unit 2 for five cycles, then release.
      step(1'b1, 2'b01, 32'h12345678, 3'b000);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 2'b00, 32'h55555555, 3'b000);
         #1;
         cmp("bp out_valid", 64'(out_valid), 64'h2);
         cmp("bp out_data", 64'(out_data), 64'h12345678);
         cmp("bp in_ready", 64'(in_ready), 64'h0);
         checkOutput();
         advance();
      end
      applyStimulus(1'b0, 2'b00, '0, 3'b010);
      #1;
      cmp("bp release in_ready", 64'(in_ready), 64'h1);
      checkOutput();
      advance();
      step(1'b0, 2'b00, '0, 3'b000);

      // Ready from non-target units must not complete a transfer.
      step(1'b1, 2'b10, 32'h0BADF00D, 3'b000);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 2'b00, '0, 3'b011);
         #1;
         cmp("nontarget out_valid", 64'(out_valid), 64'h4);
         cmp("nontarget in_ready", 64'(in_ready), 64'h0);
         checkOutput();
         advance();
      end
      step(1'b0, 2'b00, '0, 3'b100);
      step(1'b0, 2'b00, '0, 3'b000);

      // Streaming: 16 legal bundles back to back with all units ready.
      dut_log_data.delete();
      dut_log_valid.delete();
      for (int i = 0; i < 16; i++) begin
         rs = 2'($urandom_range(0, 2));
         rd = $urandom;
         sent_data.push_back(rd);
         sent_valid.push_back(3'(1 << rs));
         step(1'b1, rs, rd, 3'b111);
      end
      step(1'b0, 2'b00, '0, 3'b111);
      cmp("stream count", 64'(dut_log_data.size()), 64'd16);
      for (int i = 0; i < 16; i++) begin
         if (i < dut_log_data.size()) begin
            cmp($sformatf("stream%0d data", i), 64'(dut_log_data[i]), 64'(sent_data[i]));
            cmp($sformatf("stream%0d valid", i), 64'(dut_log_valid[i]), 64'(sent_valid[i]));
         end
      end

      // Randomised traffic, including illegal selects and toggling ready.
      for (int i = 0; i < 200; i++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
              3'($urandom_range(0, 7)));
      end
      step(1'b0, 2'b00, '0, 3'b111);

      // Saturation of the illegal-select counter.
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 2'b11, 32'h0000DEAD, 3'b111);
      end
      applyStimulus(1'b0, 2'b00, '0, 3'b111);
      #1;
      cmp("saturated illegal_cnt", 64'(illegal_cnt), 64'(CNT_MAX));
      cmp("saturated out_valid", 64'(out_valid), 64'h0);
      checkOutput();
      advance();

      // Asynchronous reset mid-transfer, with no clock edge in between.
      step(1'b1, 2'b01, 32'hFEEDFACE, 3'b000);
      applyStimulus(1'b0, 2'b00, '0, 3'b000);
      #1;
      cmp("pre-reset out_valid", 64'(out_valid), 64'h2);
      #1;
      rst_n = 1'b0;
      #1;
      cmp("async reset out_valid", 64'(out_valid), 64'h0);
      cmp("async reset in_ready", 64'(in_ready), 64'h1);
      cmp("async reset illegal_cnt", 64'(illegal_cnt), 64'h0);
      cmp("async reset out_data", 64'(out_data), 64'h0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      step(1'b1, 2'b00, 32'h00C0FFEE, 3'b001);
      step(1'b0, 2'b00, '0, 3'b001);
      step(1'b0, 2'b00, '0, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
